// File: rtl/cpu_controller_if.sv
// Controller <-> instruction ROM / datapath signal bundle.
// The master side is the sequencer; the slave side is the ROM plus datapath.
interface cpu_controller_if #(
  parameter int PC_W = 7
);
  logic [15:0]     ir_data;
  logic [PC_W-1:0] pc_addr;
  logic [7:0]      d_addr;
  logic            d_wr;
  logic [1:0]      rf_s;
  logic [3:0]      rf_w_addr;
  logic            rf_w_en;
  logic [3:0]      rf_ra_addr;
  logic [3:0]      rf_rb_addr;
  logic [2:0]      alu_s0;
  logic [3:0]      state;
  logic            halted;

  modport master (
    input  ir_data,
    output pc_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
           rf_ra_addr, rf_rb_addr, alu_s0, state, halted
  );

  modport slave (
    output ir_data,
    input  pc_addr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
           rf_ra_addr, rf_rb_addr, alu_s0, state, halted
  );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit CPU.
// Drives the ROM address and every datapath control from PC, IR and state.
//
// state  | meaning
// INIT   | reset state, leaves on first clock after release
// FETCH  | PC presented to the synchronous ROM
// DECODE | ROM data valid; choose execute state, latch IR, bump PC
// NOOP   | no-op (also every unused opcode)
// LOAD_A | present data address, DMem latches it
// LOAD_B | write DMem_Q into R[IR[11:8]]
// STORE  | D[IR[7:0]] <- R[IR[11:8]]
// ADD    | R[IR[3:0]] <- R[IR[11:8]] + R[IR[7:4]]
// SUB    | R[IR[3:0]] <- R[IR[11:8]] - R[IR[7:4]]
// HALT   | parked until reset
module cpu_controller #(
  parameter int PC_W = 7
) (
  input logic             clk,
  input logic             rst_n,
  cpu_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;

  logic            d_wr;
  logic [1:0]      rf_s;
  logic            rf_w_en;
  logic [2:0]      alu_s;
  logic            halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        ir_q <= bus.ir_data;
        pc_q <= pc_q + PC_W'(1);
      end
    end
  end

  // Decode looks at the live ROM word, since IR is only loaded on the DECODE exit edge.
  always_comb begin
    state_d = state_q;
    d_wr    = 1'b0;
    rf_s    = 2'b00;
    rf_w_en = 1'b0;
    alu_s   = 3'b000;
    halted  = 1'b0;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.ir_data[15:12])
          4'h1:    state_d = S_STORE;
          4'h2:    state_d = S_LOAD_A;
          4'h3:    state_d = S_ADD;
          4'h4:    state_d = S_SUB;
          4'h5:    state_d = S_HALT;
          default: state_d = S_NOOP;
        endcase
      end
      S_NOOP:   state_d = S_FETCH;
      S_LOAD_A: begin
        rf_s    = 2'b01;
        state_d = S_LOAD_B;
      end
      S_LOAD_B: begin
        rf_s    = 2'b01;
        rf_w_en = 1'b1;
        state_d = S_FETCH;
      end
      S_STORE: begin
        d_wr    = 1'b1;
        state_d = S_FETCH;
      end
      S_ADD: begin
        alu_s   = 3'b001;
        rf_w_en = 1'b1;
        state_d = S_FETCH;
      end
      S_SUB: begin
        alu_s   = 3'b010;
        rf_w_en = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default:  state_d = S_INIT;
    endcase
  end

  assign bus.pc_addr    = pc_q;
  assign bus.d_addr     = ir_q[7:0];
  assign bus.rf_ra_addr = ir_q[11:8];
  assign bus.rf_rb_addr = ir_q[7:4];
  // LOAD names its destination in the same field ADD/SUB use for Ra.
  assign bus.rf_w_addr  = (state_q == S_LOAD_A || state_q == S_LOAD_B) ? ir_q[11:8] : ir_q[3:0];
  assign bus.d_wr       = d_wr;
  assign bus.rf_s       = rf_s;
  assign bus.rf_w_en    = rf_w_en;
  assign bus.alu_s0     = alu_s;
  assign bus.state      = state_q;
  assign bus.halted     = halted;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: ROM + datapath models, write scoreboard, timing checks.
module tb_cpu_controller;

  typedef struct packed {
    logic        is_mem;
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst2_n = 1'b1;
  always #5 clk = ~clk;

  cpu_controller_if #(.PC_W(7)) bus();
  cpu_controller_if #(.PC_W(2)) bus2();

  cpu_controller #(.PC_W(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  cpu_controller #(.PC_W(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2.master));

  logic [15:0] rom [128];
  logic [15:0] rom2 [4];
  logic [15:0] rf_m [16];
  logic [15:0] dmem_m [256];
  logic [15:0] dmem_q;
  logic [15:0] alu_q;
  logic [15:0] wb_data;

  logic        pl_req = 1'b0;
  logic        pl_rf = 1'b0;
  logic [7:0]  pl_addr = 8'h00;
  logic [15:0] pl_data = 16'h0000;

  wr_t exp_q [$];
  int  n_checks = 0;
  int  n_fail = 0;

  always_comb begin
    alu_q = rf_m[bus.rf_ra_addr];
    case (bus.alu_s0)
      3'b001:  alu_q = rf_m[bus.rf_ra_addr] + rf_m[bus.rf_rb_addr];
      3'b010:  alu_q = rf_m[bus.rf_ra_addr] - rf_m[bus.rf_rb_addr];
      default: alu_q = rf_m[bus.rf_ra_addr];
    endcase
    wb_data = (bus.rf_s == 2'b01) ? dmem_q : alu_q;
  end

  // ROM + datapath environment model
  always @(posedge clk) begin
    if (pl_req) begin
      if (pl_rf) rf_m[pl_addr[3:0]] <= pl_data;
      else       dmem_m[pl_addr]    <= pl_data;
    end else begin
      if (bus.rf_w_en) rf_m[bus.rf_w_addr] <= wb_data;
      if (bus.d_wr)    dmem_m[bus.d_addr]  <= rf_m[bus.rf_ra_addr];
    end
    dmem_q       <= dmem_m[bus.d_addr];
    bus.ir_data  <= rom[bus.pc_addr];
    bus2.ir_data <= rom2[bus2.pc_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every write strobe pops one expected write
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rf_w_en || bus.d_wr) begin
        wr_t got;
        got.is_mem = bus.d_wr;
        got.addr   = bus.d_wr ? bus.d_addr : {4'h0, bus.rf_w_addr};
        got.data   = bus.d_wr ? rf_m[bus.rf_ra_addr] : wb_data;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {7'h0, got}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write_txn", {7'h0, got}, {7'h0, e});
        end
      end
      check("strobe_excl", {31'h0, bus.d_wr & bus.rf_w_en}, 32'h0);
      check("rf_s_state", {31'h0, (bus.rf_s == 2'b01)},
            {31'h0, (bus.state == 4'd4 || bus.state == 4'd5)});
    end
  end

  task automatic preload(input logic is_rf, input logic [7:0] a, input logic [15:0] d);
    pl_rf = is_rf; pl_addr = a; pl_data = d; pl_req = 1'b1;
    @(posedge clk); #1;
    pl_req = 1'b0;
  endtask

  task automatic push_exp(input logic is_mem, input logic [7:0] a, input logic [15:0] d);
    wr_t e;
    e.is_mem = is_mem; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    int halt_at;
    int sub_cnt;
    int wen_cnt;
    int dwr_cnt;
    int k;
    logic [1:0] fetch_seen [5];
    logic [1:0] fetch_exp  [5];
    fetch_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2101;
    rom[1] = 16'h2202;
    rom[2] = 16'h3123;
    rom[3] = 16'h1303;
    rom[4] = 16'h5000;
    rom2[0] = 16'h0000; rom2[1] = 16'hF000; rom2[2] = 16'h0000; rom2[3] = 16'h0000;

    #1 rst_n = 1'b0; rst2_n = 1'b0;
    @(posedge clk); #1;
    check("rst_state", {28'h0, bus.state}, 32'd0);
    check("rst_pc", {25'h0, bus.pc_addr}, 32'd0);
    check("rst_strobes", {23'h0, bus.d_wr, bus.rf_w_en, bus.rf_s, bus.alu_s0, bus.halted}, 32'h0);
    for (int i = 0; i < 16; i++) preload(1'b1, 8'(i), 16'h0000);
    preload(1'b0, 8'h01, 16'd5);
    preload(1'b0, 8'h02, 16'd7);
    preload(1'b0, 8'h03, 16'd0);

    // Reset in the middle of ADD: the pending R3 write must never appear
    push_exp(1'b0, 8'h01, 16'd5);
    push_exp(1'b0, 8'h02, 16'd7);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.state == 4'd7) break;
    end
    check("reach_add", {28'h0, bus.state}, 32'd7);
    check("add_wen_before_rst", {31'h0, bus.rf_w_en}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_wen", {31'h0, bus.rf_w_en}, 32'd0);
    check("abort_state", {28'h0, bus.state}, 32'd0);
    check("abort_pc", {25'h0, bus.pc_addr}, 32'd0);
    check("abort_strobes", {23'h0, bus.d_wr, bus.rf_w_en, bus.rf_s, bus.alu_s0, bus.halted}, 32'h0);
    check("abort_queue_empty", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_r3_unwritten", {16'h0, rf_m[3]}, 32'd0);

    // Full program: LOAD, LOAD, ADD, STORE, HALT
    push_exp(1'b0, 8'h01, 16'd5);
    push_exp(1'b0, 8'h02, 16'd7);
    push_exp(1'b0, 8'h03, 16'd12);
    push_exp(1'b1, 8'h03, 16'd12);
    @(negedge clk); rst_n = 1'b1;
    halt_at = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        check("first_fetch_state", {28'h0, bus.state}, 32'd1);
        check("first_fetch_addr", {25'h0, bus.pc_addr}, 32'd0);
      end
      if (bus.halted && halt_at < 0) halt_at = i;
      if (halt_at > 0 && i >= halt_at + 5) break;
    end
    check("halt_cycle", halt_at, 32'd17);
    check("halt_state", {28'h0, bus.state}, 32'd9);
    check("halt_pc", {25'h0, bus.pc_addr}, 32'd5);
    check("r3_value", {16'h0, rf_m[3]}, 32'd12);
    check("d3_value", {16'h0, dmem_m[3]}, 32'd12);
    check("prog1_queue_empty", exp_q.size(), 32'd0);

    // SUB with wrap, unknown opcode, NOOP, HALT
    rst_n = 1'b0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h4456;
    rom[1] = 16'hF000;
    rom[2] = 16'h0000;
    rom[3] = 16'h5000;
    preload(1'b1, 8'h04, 16'd3);
    preload(1'b1, 8'h05, 16'd5);
    push_exp(1'b0, 8'h06, 16'hFFFE);
    @(negedge clk); rst_n = 1'b1;
    halt_at = -1; sub_cnt = 0; wen_cnt = 0; dwr_cnt = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (bus.alu_s0 == 3'b010) sub_cnt++;
      if (bus.rf_w_en) wen_cnt++;
      if (bus.d_wr) dwr_cnt++;
      if (i == 3) check("pc_after_sub", {25'h0, bus.pc_addr}, 32'd1);
      if (i == 6) check("pc_after_f", {25'h0, bus.pc_addr}, 32'd2);
      if (i == 9) check("pc_after_noop", {25'h0, bus.pc_addr}, 32'd3);
      if (bus.halted && halt_at < 0) halt_at = i;
      if (halt_at > 0 && i >= halt_at + 3) break;
    end
    check("prog2_halt_cycle", halt_at, 32'd12);
    check("sub_cycles", sub_cnt, 32'd1);
    check("prog2_wen_cycles", wen_cnt, 32'd1);
    check("prog2_dwr_cycles", dwr_cnt, 32'd0);
    check("r6_value", {16'h0, rf_m[6]}, 32'hFFFE);
    check("prog2_queue_empty", exp_q.size(), 32'd0);

    // PC_W=2 wrap: fetch addresses 0,1,2,3,0
    @(negedge clk); rst2_n = 1'b1;
    k = 0;
    for (int i = 0; i < 40 && k < 5; i++) begin
      @(posedge clk); #1;
      if (bus2.state == 4'd1) begin
        fetch_seen[k] = bus2.pc_addr;
        k++;
      end
      check("pcw2_no_writes", {30'h0, bus2.d_wr, bus2.rf_w_en}, 32'h0);
    end
    check("pcw2_fetch_count", k, 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < k) check("pcw2_fetch_addr", {30'h0, fetch_seen[i]}, {30'h0, fetch_exp[i]});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
